multi_button_processor: RTL and testbench

Parametrised successor to the single-button processor: `NUM_BUTTONS` independent channels, each with a synchroniser and debouncing on both edges. Each channel classifies a press as short or long, and can auto-repeat while a long press is held. It sits between the raw board pushbuttons and the scoreboard counter logic on the 1 kHz domain. Event outputs are single-cycle pulses; a per-channel level output reports the long-hold state.

---
 rtl/multi_button_processor.sv | 170 +++++++++++++++++
 tb/tb_multi_button_processor.sv | 122 ++++++++++++
 2 files changed

// File: rtl/multi_button_processor.sv
// multi_button_processor: per-channel synchronised, debounced short/long/auto-repeat button classifier
module multi_button_processor #(
  parameter int NUM_BUTTONS     = 2,
  parameter int DEBOUNCE_TIME   = 20,
  parameter int LONG_PRESS_TIME = 1500,
  parameter int REPEAT_TIME     = 250
) (
  input  logic                   clk_1khz,
  input  logic                   rst_i,
  input  logic [NUM_BUTTONS-1:0] pushbutton_i,
  input  logic                   repeat_en_i,
  output logic [NUM_BUTTONS-1:0] short_o,
  output logic [NUM_BUTTONS-1:0] long_o,
  output logic [NUM_BUTTONS-1:0] repeat_o,
  output logic [NUM_BUTTONS-1:0] held_o
);
  localparam int DW = $clog2(DEBOUNCE_TIME + 1);
  localparam int HW = $clog2(LONG_PRESS_TIME + 1);
  localparam int RW = $clog2(REPEAT_TIME + 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_TIME);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_TIME);
  localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_TIME);

  typedef enum logic [2:0] {IDLE, PRESS_DEB, PRESSED, HELD, RELEASE_DEB} state_e;

  logic [NUM_BUTTONS-1:0] sync_q, btn_s_q;

  always_ff @(posedge clk_1khz) begin
    if (rst_i) begin
      sync_q  <= '0;
      btn_s_q <= '0;
    end else begin
      sync_q  <= pushbutton_i;
      btn_s_q <= sync_q;
    end
  end

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
    state_e        state_q, state_d;
    logic [DW-1:0] deb_q, deb_d, deb_inc;
    logic [HW-1:0] hold_q, hold_d, hold_inc;
    logic [RW-1:0] rep_q, rep_d, rep_inc;
    logic          long_fired_q, long_fired_d;
    logic          short_q, short_d, long_q, long_d, repeat_q, repeat_d, held_q, held_d;
    logic          btn;

    assign btn      = btn_s_q[g];
    assign deb_inc  = deb_q + 1'b1;
    assign hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
    assign rep_inc  = rep_q + 1'b1;

    always_comb begin
      state_d      = state_q;
      deb_d        = deb_q;
      hold_d       = hold_q;
      rep_d        = rep_q;
      long_fired_d = long_fired_q;
      short_d      = 1'b0;
      long_d       = 1'b0;
      repeat_d     = 1'b0;
      case (state_q)
        IDLE: begin
          if (btn) begin
            if (DEBOUNCE_TIME == 1) state_d = PRESSED;
            else state_d = PRESS_DEB;
            deb_d        = DW'(1);
            hold_d       = '0;
            long_fired_d = 1'b0;
          end
        end
        PRESS_DEB: begin
          if (!btn) begin
            state_d = IDLE;
            deb_d   = '0;
          end else begin
            deb_d = deb_inc;
            if (deb_inc == DEB_MAX) begin
              state_d      = PRESSED;
              hold_d       = '0;
              long_fired_d = 1'b0;
            end
          end
        end
        PRESSED, HELD: begin
          if (!btn) begin
            deb_d = DW'(1);
            if (DEBOUNCE_TIME == 1) begin
              state_d      = IDLE;
              short_d      = !long_fired_q;
              deb_d        = '0;
              hold_d       = '0;
              rep_d        = '0;
              long_fired_d = 1'b0;
            end else begin
              state_d = RELEASE_DEB;
            end
          end else if (state_q == PRESSED) begin
            hold_d = hold_inc;
            if (hold_inc == HOLD_MAX) begin
              state_d      = HELD;
              long_d       = 1'b1;
              long_fired_d = 1'b1;
              rep_d        = '0;
            end
          end else if (repeat_en_i) begin
            rep_d    = (rep_inc == REP_MAX) ? '0 : rep_inc;
            repeat_d = rep_inc == REP_MAX;
          end else begin
            rep_d = '0;
          end
        end
        RELEASE_DEB: begin
          // hold and repeat counters stay frozen so a bounce resumes where it left off
          if (btn) begin
            if (long_fired_q) state_d = HELD;
            else state_d = PRESSED;
            deb_d = '0;
          end else begin
            deb_d = deb_inc;
            if (deb_inc == DEB_MAX) begin
              state_d      = IDLE;
              short_d      = !long_fired_q;
              deb_d        = '0;
              hold_d       = '0;
              rep_d        = '0;
              long_fired_d = 1'b0;
            end
          end
        end
        default: begin
          state_d      = IDLE;
          deb_d        = '0;
          hold_d       = '0;
          rep_d        = '0;
          long_fired_d = 1'b0;
        end
      endcase
      held_d = (state_d == HELD) || ((state_d == RELEASE_DEB) && long_fired_d);
    end

    always_ff @(posedge clk_1khz) begin
      if (rst_i) begin
        state_q      <= IDLE;
        deb_q        <= '0;
        hold_q       <= '0;
        rep_q        <= '0;
        long_fired_q <= 1'b0;
        short_q      <= 1'b0;
        long_q       <= 1'b0;
        repeat_q     <= 1'b0;
        held_q       <= 1'b0;
      end else begin
        state_q      <= state_d;
        deb_q        <= deb_d;
        hold_q       <= hold_d;
        rep_q        <= rep_d;
        long_fired_q <= long_fired_d;
        short_q      <= short_d;
        long_q       <= long_d;
        repeat_q     <= repeat_d;
        held_q       <= held_d;
      end
    end

    assign short_o[g]  = short_q;
    assign long_o[g]   = long_q;
    assign repeat_o[g] = repeat_q;
    assign held_o[g]   = held_q;
  end
endmodule

// File: tb/tb_multi_button_processor.sv
// tb_multi_button_processor: scoreboard bench comparing every output cycle against timeline-derived expectations
module tb_multi_button_processor;
  logic       clk_1khz = 1'b0;
  logic       rst_i = 1'b1;
  logic [1:0] pushbutton_i = '0;
  logic       repeat_en_i = 1'b0;
  logic [1:0] short_o, long_o, repeat_o, held_o;

  multi_button_processor #(
    .NUM_BUTTONS(2), .DEBOUNCE_TIME(4), .LONG_PRESS_TIME(20), .REPEAT_TIME(8)
  ) dut (
    .clk_1khz(clk_1khz), .rst_i(rst_i), .pushbutton_i(pushbutton_i), .repeat_en_i(repeat_en_i),
    .short_o(short_o), .long_o(long_o), .repeat_o(repeat_o), .held_o(held_o)
  );

  always #5 clk_1khz = ~clk_1khz;

  int checks = 0;
  int errors = 0;
  bit b0[128], b1[128], ren[128], rs[128];
  logic [7:0] ex[128];
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b (short,long,repeat,held)", tag, got, want);
    end
  endtask

  task automatic clr();
    for (int t = 0; t < 128; t++) begin
      b0[t] = 0; b1[t] = 0; ren[t] = 0; rs[t] = 0; ex[t] = '0;
    end
  endtask

  task automatic press(input int ch, input int from, input int to);
    for (int t = from; t < to; t++) if (ch == 0) b0[t] = 1; else b1[t] = 1;
  endtask

  // kind: 3 short, 2 long, 1 repeat
  task automatic pulse(input int kind, input int ch, input int t);
    ex[t][kind*2+ch] = 1'b1;
  endtask

  task automatic held(input int ch, input int from, input int to);
    for (int t = from; t < to; t++) ex[t][ch] = 1'b1;
  endtask

  task automatic run(input string name, input int len);
    for (int t = 0; t < len; t++) begin
      @(negedge clk_1khz);
      pushbutton_i = {b1[t], b0[t]};
      repeat_en_i  = ren[t];
      rst_i        = rs[t];
      exp_q.push_back(ex[t]);
      @(posedge clk_1khz);
      #1;
      check($sformatf("%s t=%0d", name, t), {short_o, long_o, repeat_o, held_o}, exp_q.pop_front());
    end
  endtask

  initial begin
    clr();
    for (int t = 0; t < 3; t++) rs[t] = 1;
    press(0, 0, 3);
    run("reset", 8);

    clr();
    press(0, 0, 12);
    pulse(3, 0, 17);
    run("short", 25);

    clr();
    press(1, 0, 50);
    for (int t = 0; t < 62; t++) ren[t] = 1;
    pulse(2, 1, 25);
    pulse(1, 1, 33); pulse(1, 1, 41); pulse(1, 1, 49);
    held(1, 25, 55);
    run("long_repeat", 62);

    clr();
    b0[0] = 1; b0[2] = 1;
    press(0, 4, 15);
    press(0, 17, 40);
    pulse(2, 0, 32);
    held(0, 32, 45);
    run("bounce", 55);

    clr();
    press(1, 0, 50);
    pulse(2, 1, 25);
    held(1, 25, 55);
    run("repeat_off", 62);

    clr();
    press(0, 0, 60);
    rs[22] = 1;
    pulse(2, 0, 48);
    held(0, 48, 65);
    run("reset_mid", 75);

    clr();
    press(0, 0, 30);
    press(1, 0, 30);
    pulse(2, 0, 25); pulse(2, 1, 25);
    held(0, 25, 35); held(1, 25, 35);
    run("concurrent", 45);

    clr();
    press(0, 0, 60);
    for (int t = 0; t < 75; t++) ren[t] = (t < 35 || t > 37);
    pulse(2, 0, 25);
    pulse(1, 0, 33); pulse(1, 0, 45); pulse(1, 0, 53); pulse(1, 0, 61);
    held(0, 25, 65);
    run("repeat_toggle", 75);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
